// File: rtl/carry_look_ahead_adder_4b.sv
// 4-bit carry-look-ahead adder with a combinational result, a registered copy, and group P/G for cascading.
// Optional CLA_OVERFLOW_EN adds signed overflow outputs ovf (combinational) and ovf_q (registered).
module carry_look_ahead_adder_4b (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  input  logic       in_valid,
  output logic [3:0] sum,
  output logic       c_out,
  output logic       p_grp,
  output logic       g_grp,
  output logic [3:0] sum_q,
  output logic       c_out_q,
  output logic       out_valid
`ifdef CLA_OVERFLOW_EN
  ,
  output logic       ovf,
  output logic       ovf_q
`endif
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every carry is a flat sum-of-products of g/p and c_in; no carry feeds another.
  assign w_c[0] = c_in;
  assign w_c[1] = w_g[0]
                | (w_p[0] & c_in);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & c_in);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & c_in);
  assign w_c[4] = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c_in);

  assign sum   = w_p ^ w_c[3:0];
  assign c_out = w_c[4];

  // Group terms exclude c_in so a second-level CLA can combine them.
  assign p_grp = &w_p;
  assign g_grp = w_g[3]
               | (w_p[3] & w_g[2])
               | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

  // Handshake: in_valid is a one-cycle capture strobe with no ready; out_valid
  // follows it one edge later, and the registered result holds while in_valid is low.
  logic [3:0] r_sum_q;
  logic       r_c_out_q;
  logic       r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_q     <= 4'd0;
      r_c_out_q   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum_q   <= sum;
        r_c_out_q <= c_out;
      end
    end
  end

  assign sum_q     = r_sum_q;
  assign c_out_q   = r_c_out_q;
  assign out_valid = r_out_valid;

`ifdef CLA_OVERFLOW_EN
  logic w_ovf;
  logic r_ovf_q;

  assign w_ovf = w_c[4] ^ w_c[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_q <= 1'b0;
    end else if (in_valid) begin
      r_ovf_q <= w_ovf;
    end
  end

  assign ovf   = w_ovf;
  assign ovf_q = r_ovf_q;
`endif

endmodule

// File: tb/tb_carry_look_ahead_adder_4b.sv
// Self-checking bench for carry_look_ahead_adder_4b: arithmetic reference model, directed and random stimulus.
module tb_carry_look_ahead_adder_4b;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       c_in;
  logic       in_valid;
  logic [3:0] sum;
  logic       c_out;
  logic       p_grp;
  logic       g_grp;
  logic [3:0] sum_q;
  logic       c_out_q;
  logic       out_valid;
`ifdef CLA_OVERFLOW_EN
  logic       ovf;
  logic       ovf_q;
`endif

  carry_look_ahead_adder_4b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .in_valid  (in_valid),
    .sum       (sum),
    .c_out     (c_out),
    .p_grp     (p_grp),
    .g_grp     (g_grp),
    .sum_q     (sum_q),
    .c_out_q   (c_out_q),
    .out_valid (out_valid)
`ifdef CLA_OVERFLOW_EN
    ,
    .ovf       (ovf),
    .ovf_q     (ovf_q)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic
  function automatic logic [4:0] add_ref(input logic [3:0] x, input logic [3:0] y, input logic c);
    int s;
    s = int'(x) + int'(y) + int'(c);
    return s[4:0];
  endfunction

  function automatic logic ovf_ref(input logic [3:0] x, input logic [3:0] y, input logic c);
    int sx;
    int sy;
    int s;
    sx = x[3] ? int'(x) - 16 : int'(x);
    sy = y[3] ? int'(y) - 16 : int'(y);
    s  = sx + sy + int'(c);
    return (s > 7) || (s < -8);
  endfunction

  // Registered-path model and scoreboard queue
  logic [4:0] m_q;
  logic       m_valid;
  logic       m_ovf_q;
  logic [4:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q     = 5'd0;
      m_valid = 1'b0;
      m_ovf_q = 1'b0;
      exp_q.delete();
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        m_q     = add_ref(a, b, c_in);
        m_ovf_q = ovf_ref(a, b, c_in);
        exp_q.push_back(m_q);
      end
    end
  end

  // Compare process: every falling edge, away from input changes
  always @(negedge clk) begin
    logic [4:0] front;
    front = 5'd0;
    if (m_valid && exp_q.size() > 0) front = exp_q.pop_front();
    if (cmp_en) begin
      check("comb_sum", {27'd0, c_out, sum}, {27'd0, add_ref(a, b, c_in)});
      check("p_grp", {31'd0, p_grp}, {31'd0, (a ^ b) == 4'hf});
      check("g_grp", {31'd0, g_grp}, {31'd0, add_ref(a, b, 1'b0) > 5'd15});
      check("reg_sum", {27'd0, c_out_q, sum_q}, {27'd0, m_q});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) check("scoreboard", {27'd0, c_out_q, sum_q}, {27'd0, front});
`ifdef CLA_OVERFLOW_EN
      check("ovf", {31'd0, ovf}, {31'd0, ovf_ref(a, b, c_in)});
      check("ovf_q", {31'd0, ovf_q}, {31'd0, m_ovf_q});
`endif
    end
  end

  // Driver tasks
  task automatic drive(input logic [3:0] x, input logic [3:0] y, input logic c, input logic v);
    @(posedge clk);
    #1;
    a = x;
    b = y;
    c_in = c;
    in_valid = v;
  endtask

  task automatic comb_case(input logic [3:0] x, input logic [3:0] y, input logic c,
                           input logic [3:0] es, input logic ec, input string name);
    a = x;
    b = y;
    c_in = c;
    #1;
    check({name, "_sum"}, {28'd0, sum}, {28'd0, es});
    check({name, "_cout"}, {31'd0, c_out}, {31'd0, ec});
  endtask

  initial begin
    a = 4'd0;
    b = 4'd0;
    c_in = 1'b0;
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_sum_q", {28'd0, sum_q}, 32'd0);
    check("rst_c_out_q", {31'd0, c_out_q}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("zero_sum", {27'd0, c_out, sum}, 32'd0);
    check("zero_p_grp", {31'd0, p_grp}, 32'd0);
    check("zero_g_grp", {31'd0, g_grp}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed combinational literals
    comb_case(4'b1011, 4'b1101, 1'b0, 4'b1000, 1'b1, "d1");
    comb_case(4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, "d2");
    comb_case(4'b1001, 4'b0110, 1'b1, 4'b0000, 1'b1, "d3");
    comb_case(4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, "d4");
    comb_case(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, "max");

    // Group terms
    a = 4'b1010; b = 4'b0101; c_in = 1'b0; #1;
    check("pg_p", {31'd0, p_grp}, 32'd1);
    check("pg_g", {31'd0, g_grp}, 32'd0);
    check("pg_cout0", {31'd0, c_out}, 32'd0);
    c_in = 1'b1; #1;
    check("pg_cout1", {31'd0, c_out}, 32'd1);
    a = 4'b1000; b = 4'b1000; c_in = 1'b0; #1;
    check("g_only", {31'd0, g_grp}, 32'd1);

`ifdef CLA_OVERFLOW_EN
    a = 4'b0111; b = 4'b0001; c_in = 1'b0; #1;
    check("ovf_pos", {31'd0, ovf}, 32'd1);
    a = 4'b1111; b = 4'b0001; c_in = 1'b0; #1;
    check("ovf_none", {31'd0, ovf}, 32'd0);
`endif

    // Exhaustive sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          a = ia[3:0];
          b = ib[3:0];
          c_in = ic[0];
          #1;
          check("sweep_sum", {27'd0, c_out, sum}, ia + ib + ic);
          check("sweep_inv", {31'd0, c_out}, {31'd0, g_grp | (p_grp & c_in)});
        end
      end
    end

    // Registered path, directed
    drive(4'b0110, 4'b0111, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("reg_lit_sum", {28'd0, sum_q}, {28'd0, 4'b1110});
    check("reg_lit_cout", {31'd0, c_out_q}, 32'd0);
    check("reg_lit_valid", {31'd0, out_valid}, 32'd1);
    a = 4'd3; b = 4'd9; c_in = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("hold_sum", {28'd0, sum_q}, {28'd0, 4'b1110});
    check("hold_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset between edges
    drive(4'd2, 4'd3, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_sum_q", {28'd0, sum_q}, 32'd0);
    check("async_c_out_q", {31'd0, c_out_q}, 32'd0);
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_comb", {27'd0, c_out, sum}, 32'd5);
    #1 rst_n = 1'b1;
    in_valid = 1'b0;

    // Randomized stream, model-checked every cycle
    cmp_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      if (n == 200) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end
    drive(4'd0, 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/carry_look_ahead_adder_4b.md
Name:
carry_look_ahead_adder_4b

Overview:
- 4-bit carry-look-ahead adder. All carries are computed in parallel from generate/propagate terms; there is no ripple chain.
- Provides a zero-latency combinational result for datapath use.
- Also provides a 1-cycle registered copy with a valid flag, for pipelined consumers in the arithmetic unit.
- Exports group propagate/generate so the block can be cascaded into a 16-bit two-level CLA.

Parameters:
- None. Width is fixed at 4 bits.

Ports:
- clk  input  1  rising-edge clock for the registered copy
- rst_n  input  1  asynchronous reset, active-low
- a  input  4  operand A, unsigned
- b  input  4  operand B, unsigned
- c_in  input  1  carry into bit 0
- in_valid  input  1  capture strobe for the registered stage
- sum  output  4  combinational sum bits
- c_out  output  1  combinational carry out of bit 3
- p_grp  output  1  group propagate
- g_grp  output  1  group generate
- sum_q  output  4  registered sum
- c_out_q  output  1  registered carry out
- out_valid  output  1  registered result valid

Behaviour:
- Per bit i = 0..3:
  - g_i = a_i & b_i
  - p_i = a_i ^ b_i
- Carries, each a flat sum-of-products with no carry term fed from another carry:
  - c0 = c_in
  - c1 = g0 | p0·c0
  - c2 = g1 | p1·g0 | p1·p0·c0
  - c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·c0
  - c4 = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 | p3·p2·p1·p0·c0
- Outputs:
  - sum_i = p_i ^ c_i
  - c_out = c4
- Group terms:
  - p_grp = p3·p2·p1·p0
  - g_grp = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0
  - Invariant: c_out == g_grp | (p_grp & c_in)
- Arithmetic contract: {c_out, sum} == a + b + c_in, evaluated as a 5-bit unsigned value, for all 512 input combinations.
- Combinational path (sum, c_out, p_grp, g_grp):
  - Pure logic, no clock dependency.
  - Settles within one simulation delta-cycle sequence of any input change.
  - Unaffected by rst_n.
- Registered path, evaluated on each rising clk edge:
  - in_valid = 1: {c_out_q, sum_q} <= {c_out, sum}.
  - in_valid = 0: {c_out_q, sum_q} hold.
  - out_valid <= in_valid on every edge, so latency is 1 cycle.
  - Back-to-back in_valid on consecutive cycles is supported at full throughput; there is no backpressure.
- Reset:
  - rst_n low asynchronously forces sum_q = 0, c_out_q = 0, out_valid = 0, regardless of clk.
  - Reset asserted mid-stream discards the in-flight result.
  - After rst_n deasserts, the first rising edge with in_valid = 1 produces out_valid = 1 on the following cycle.
- Boundary cases:
  - 15+15+1 = 31 gives sum = 1111, c_out = 1.
  - 0+0+0 gives all zeros, p_grp = 0, g_grp = 0.
  - a ^ b = 1111 gives p_grp = 1, so c_out = c_in.

Optional Feature:
- Macro: CLA_OVERFLOW_EN.
- Defined:
  - Adds output ovf (1 bit, combinational), ovf = c4 ^ c3. This is two's-complement signed overflow of a + b + c_in.
  - Adds output ovf_q (1 bit). It is registered alongside sum_q under the same in_valid and reset rules, with reset value 0.
- Undefined:
  - Neither port exists and no logic is generated.
  - All other behaviour is identical.

Test Plan:
- Directed combinational cases (sum, c_out):
  - a=1011, b=1101, c_in=0 -> sum=1000, c_out=1
  - a=0101, b=0011, c_in=0 -> sum=1000, c_out=0
  - a=1001, b=0110, c_in=1 -> sum=0000, c_out=1
  - a=1111, b=1111, c_in=0 -> sum=1110, c_out=1
- Exhaustive sweep: a and b each 0..15, c_in each 0..1 (512 cases), 1 ns settle per case:
  - {c_out, sum} === a + b + c_in
  - c_out === g_grp | (p_grp & c_in)
  - The run reports zero mismatches.
- Group terms:
  - a=1010, b=0101 -> p_grp=1, g_grp=0, and c_out follows c_in.
  - a=1000, b=1000 -> g_grp=1.
- Registered path:
  - Drive a=0110, b=0111, c_in=1 with in_valid=1 for one edge -> next cycle sum_q=1110, c_out_q=0, out_valid=1.
  - Then in_valid=0 with new inputs -> sum_q holds 1110 and out_valid=0.
- Reset:
  - Pulse rst_n low between edges while out_valid=1 -> sum_q=0000, c_out_q=0, out_valid=0 immediately.
  - Combinational sum is unchanged during the pulse.
- With CLA_OVERFLOW_EN defined:
  - a=0111, b=0001, c_in=0 -> ovf=1
  - a=1111, b=0001, c_in=0 -> ovf=0
  - ovf_q tracks ovf with 1-cycle latency.
